instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch-stage controller that drives the synchronous instruction memory: it owns the program counter and issues one fetch address per cycle. It tags the instruction returned one cycle later with its PC and a valid bit, and discards wrong-path fetches on control-flow redirects. It also keeps a small return-address stack (RAS) that decode uses for CALL/RET. It sits between the instruction memory and the decode stage.

## Interface
- `ADDR_W`, 16, PC / fetch address width
- `INSTR_W`, 16, instruction width
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2)
- `RESET_PC`, 16'h0000, PC value loaded on reset

- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold request from downstream pipeline
- `redirect`  in  1  one-cycle pulse: take `redirect_pc` (JMP, taken branch, CALL, RET)
- `redirect_pc`  in  ADDR_W  redirect target
- `ras_push`  in  1  one-cycle pulse on CALL: push `ras_push_addr`
- `ras_push_addr`  in  ADDR_W  return address (CALL PC + 1)
- `ras_pop`  in  1  one-cycle pulse on RET
- `imem_address`  out  ADDR_W  fetch address to instruction memory (equals `pc`)
- `imem_stall`  out  1  hold to instruction memory
- `imem_instruction`  in  INSTR_W  registered memory output
- `if_instruction`  out  INSTR_W  instruction to decode (pass-through of `imem_instruction`)
- `if_pc`  out  ADDR_W  PC of `if_instruction`
- `if_valid`  out  1  `if_instruction` is on the correct path
- `ras_top`  out  ADDR_W  current top of RAS; 0 when empty
- `ras_empty`  out  1  RAS holds no entries
- `ras_overflow`  out  1  sticky: a push occurred while full
- `ras_underflow`  out  1  sticky: a pop occurred while empty

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `pc_q`: address currently latched in memory.
  - `valid_q`.
  - RAS array, `sp` (index of next free slot, mod `RAS_DEPTH`), `count` (0..`RAS_DEPTH`).
  - Two sticky flags.
- The memory captures `mem[imem_address]` on each edge where `imem_stall`=0.
- `imem_address` = `pc` (combinational). `imem_stall` = `stall & ~redirect`.
- Per edge, priority order:
  - **redirect**: `pc` ← `redirect_pc`; `pc_q` ← `pc`; `valid_q` ← 0 (the word latched this edge is wrong-path). Overrides `stall`.
  - **stall** (no redirect): `pc`, `pc_q`, `valid_q` hold.
  - **normal**: `pc` ← `pc`+1 (mod 2^ADDR_W, so FFFF→0000); `pc_q` ← `pc`; `valid_q` ← 1.
- `if_pc` = `pc_q`; `if_valid` = `valid_q`.
- The unit does not truncate addresses to the memory size.
- RAS operations are independent of `stall` and `redirect`:
  - **Push only**: write `ras[sp]`, `sp`+1. If `count`=`RAS_DEPTH`, the oldest entry is overwritten, `count` stays saturated, and `ras_overflow` is set. Otherwise `count`+1.
  - **Pop only**: if `count`>0, `sp`−1 and `count`−1. If `count`=0, nothing changes and `ras_underflow` is set.
  - **Push and pop together**: if `count`>0, `ras[sp−1]` ← addr with `sp`/`count` unchanged. If empty, behaves as a push only.
- `ras_top` = `ras[sp−1]` when `count`>0, else 0. It is combinational, so decode can use it as `redirect_pc` in the same cycle as `ras_pop`.

## Timing
- Reset (asynchronous, immediate):
  - `pc`=`RESET_PC`, `pc_q`=0, `valid_q`=0.
  - `sp`=0, `count`=0, sticky flags=0.
  - So `if_valid`=0, `if_pc`=0, `ras_top`=0, `ras_empty`=1, `imem_address`=`RESET_PC`.
- Fetch latency: address presented in cycle N → instruction on `if_instruction` with `if_valid`=1 in cycle N+1.
- Throughput: one instruction per cycle when not stalled.
- Redirect penalty: exactly one bubble (`if_valid`=0) in the cycle after `redirect`. The target instruction appears valid in the second cycle.
- Back-to-back redirects: each one produces a bubble. The last target wins.
- `rst_n` asserted mid-stream clears state immediately. The first valid instruction (at `RESET_PC`) appears one cycle after the first edge with `rst_n`=1.
- Stall of k cycles: outputs frozen for exactly k cycles. No instruction is lost or duplicated.

## Test plan
- **Reset, then free run**: `if_valid`=0 until the first edge. Afterwards `if_pc` reads 0, 1, 2, 3… with `if_instruction`=mem[0..3] and `if_valid`=1 every cycle.
- **Stall**: `stall`=1 for 3 cycles while `if_pc`=2 → `if_pc`=2 and the instruction stay frozen for 3 cycles, then `if_pc` resumes at 3.
- **Redirect**: `redirect` with `redirect_pc`=0x000A while `pc`=2 → next cycle `if_valid`=0; following cycle `if_pc`=0x0A, valid. Repeat with `stall`=1 in the same cycle: identical result.
- **CALL/RET**: push 0x0006, then `ras_pop` with `redirect_pc`=`ras_top` → `ras_top`=0x0006 before the pop. After the pop, `ras_empty`=1 and fetch resumes at 0x0006 after one bubble.
- **RAS boundaries**:
  - 5 pushes (1..5) into depth 4 → `ras_overflow`=1; pops return 5, 4, 3, 2.
  - A fifth pop → `ras_underflow`=1, `ras_top`=0.
  - Simultaneous push(9)+pop with top=3 → `ras_top`=9, `count` unchanged.
- **Wrap-around**: redirect to 0xFFFF → `if_pc` reads 0xFFFF then 0x0000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch-stage controller: owns the PC, drives the synchronous instruction memory,
// tags returned words with PC/valid, and keeps a small return-address stack.
module instruction_fetch #(
  parameter int              ADDR_W    = 16,
  parameter int              INSTR_W   = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               ras_push,
  input  logic [ADDR_W-1:0]  ras_push_addr,
  input  logic               ras_pop,
  output logic [ADDR_W-1:0]  imem_address,
  output logic               imem_stall,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  ras_top,
  output logic               ras_empty,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              ras_wr_en;
  logic [SP_W-1:0]   ras_wr_idx;
  logic              ras_full, ras_is_empty;

  // Fetch pipeline: redirect beats stall, and the word latched on a redirect edge is wrong-path.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if_pc_d    = if_pc_q;
    valid_d    = valid_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      if_pc_d    = fetch_pc_q;
      valid_d    = 1'b0;
    end else if (!stall) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      if_pc_d    = fetch_pc_q;
      valid_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      if_pc_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if_pc_q    <= if_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_address   = fetch_pc_q;
  assign imem_stall     = stall & ~redirect;
  assign if_instruction = imem_instruction;
  assign if_pc          = if_pc_q;
  assign if_valid       = valid_q;

  assign ras_full     = (count_q == CNT_W'(RAS_DEPTH));
  assign ras_is_empty = (count_q == '0);
  assign sp_m1        = sp_q - SP_W'(1);

  // Push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    ras_wr_en   = 1'b0;
    ras_wr_idx  = sp_q;
    if (ras_push && (!ras_pop || ras_is_empty)) begin
      ras_wr_en = 1'b1;
      sp_d      = sp_q + SP_W'(1);
      if (ras_full) overflow_d = 1'b1;
      else          count_d    = count_q + CNT_W'(1);
    end else if (ras_push && ras_pop) begin
      ras_wr_en  = 1'b1;
      ras_wr_idx = sp_m1;
    end else if (ras_pop) begin
      if (ras_is_empty) begin
        underflow_d = 1'b1;
      end else begin
        sp_d    = sp_m1;
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the stack storage has no reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (ras_wr_en) ras_q[ras_wr_idx] <= ras_push_addr;
  end

  assign ras_top       = ras_is_empty ? '0 : ras_q[sp_m1];
  assign ras_empty     = ras_is_empty;
  assign ras_overflow  = overflow_q;
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for fetch/RAS behaviour plus
// hand-written sequences for mid-stream reset and a CALL/RET round trip.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, ras_push, ras_pop;
  logic [15:0] redirect_pc, ras_push_addr;
  logic [15:0] imem_address, imem_instruction, if_instruction, if_pc, ras_top;
  logic        imem_stall, if_valid, ras_empty, ras_overflow, ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .ras_push         (ras_push),
    .ras_push_addr    (ras_push_addr),
    .ras_pop          (ras_pop),
    .imem_address     (imem_address),
    .imem_stall       (imem_stall),
    .imem_instruction (imem_instruction),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_valid         (if_valid),
    .ras_top          (ras_top),
    .ras_empty        (ras_empty),
    .ras_overflow     (ras_overflow),
    .ras_underflow    (ras_underflow)
  );

  // Synchronous instruction memory whose contents are a fixed function of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  initial imem_instruction = 16'h0000;
  always @(posedge clk) if (!imem_stall) imem_instruction <= mem_word(imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall, redirect;
    logic [15:0] rpc;
    logic        push;
    logic [15:0] paddr;
    logic        pop;
    logic [15:0] e_addr, e_pc;
    logic        e_valid;
    logic [15:0] e_top;
    logic        e_empty, e_ovf, e_unf;
  } vec_t;

  localparam int NVEC = 35;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rpc,
                              input logic pu, input logic [15:0] pa, input logic po,
                              input logic [15:0] ea, input logic [15:0] ep, input logic ev,
                              input logic [15:0] et, input logic ee, input logic eo,
                              input logic eu);
    vec_t v;
    v.stall = s;  v.redirect = r; v.rpc = rpc; v.push = pu; v.paddr = pa; v.pop = po;
    v.e_addr = ea; v.e_pc = ep; v.e_valid = ev; v.e_top = et;
    v.e_empty = ee; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic idle_inputs();
    stall = 0; redirect = 0; redirect_pc = 0; ras_push = 0; ras_push_addr = 0; ras_pop = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               st rd rpc       pu pa       po | addr      if_pc     v  top      e  ov un
    vecs[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 16'h0000, 1, 16'h0000, 1, 0, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'h0001, 1, 16'h0000, 1, 0, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 16'h0002, 1, 16'h0000, 1, 0, 0);
    vecs[3]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 16'h0002, 1, 16'h0000, 1, 0, 0);
    vecs[4]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 16'h0002, 1, 16'h0000, 1, 0, 0);
    vecs[5]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0003, 16'h0002, 1, 16'h0000, 1, 0, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 16'h0003, 1, 16'h0000, 1, 0, 0);
    vecs[7]  = mk(0, 1, 16'h000A, 0, 16'h0000, 0, 16'h000A, 16'h0004, 0, 16'h0000, 1, 0, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h000B, 16'h000A, 1, 16'h0000, 1, 0, 0);
    vecs[9]  = mk(1, 1, 16'h0014, 0, 16'h0000, 0, 16'h0014, 16'h000B, 0, 16'h0000, 1, 0, 0);
    vecs[10] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0015, 16'h0014, 1, 16'h0000, 1, 0, 0);
    vecs[11] = mk(0, 1, 16'h0030, 0, 16'h0000, 0, 16'h0030, 16'h0015, 0, 16'h0000, 1, 0, 0);
    vecs[12] = mk(0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0040, 16'h0030, 0, 16'h0000, 1, 0, 0);
    vecs[13] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0041, 16'h0040, 1, 16'h0000, 1, 0, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 16'h0006, 0, 16'h0042, 16'h0041, 1, 16'h0006, 0, 0, 0);
    vecs[15] = mk(0, 1, 16'h0006, 0, 16'h0000, 1, 16'h0006, 16'h0042, 0, 16'h0000, 1, 0, 0);
    vecs[16] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0007, 16'h0006, 1, 16'h0000, 1, 0, 0);
    vecs[17] = mk(0, 1, 16'hFFFF, 0, 16'h0000, 0, 16'hFFFF, 16'h0007, 0, 16'h0000, 1, 0, 0);
    vecs[18] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 1, 16'h0000, 1, 0, 0);
    vecs[19] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 16'h0000, 1, 16'h0000, 1, 0, 0);
    vecs[20] = mk(0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0002, 16'h0001, 1, 16'h0001, 0, 0, 0);
    vecs[21] = mk(0, 0, 16'h0000, 1, 16'h0002, 0, 16'h0003, 16'h0002, 1, 16'h0002, 0, 0, 0);
    vecs[22] = mk(0, 0, 16'h0000, 1, 16'h0003, 0, 16'h0004, 16'h0003, 1, 16'h0003, 0, 0, 0);
    vecs[23] = mk(0, 0, 16'h0000, 1, 16'h0004, 0, 16'h0005, 16'h0004, 1, 16'h0004, 0, 0, 0);
    vecs[24] = mk(0, 0, 16'h0000, 1, 16'h0005, 0, 16'h0006, 16'h0005, 1, 16'h0005, 0, 1, 0);
    vecs[25] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0007, 16'h0006, 1, 16'h0004, 0, 1, 0);
    vecs[26] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 16'h0007, 1, 16'h0003, 0, 1, 0);
    vecs[27] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0009, 16'h0008, 1, 16'h0002, 0, 1, 0);
    vecs[28] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000A, 16'h0009, 1, 16'h0000, 1, 1, 0);
    vecs[29] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000B, 16'h000A, 1, 16'h0000, 1, 1, 1);
    vecs[30] = mk(1, 0, 16'h0000, 1, 16'h0003, 0, 16'h000B, 16'h000A, 1, 16'h0003, 0, 1, 1);
    vecs[31] = mk(0, 0, 16'h0000, 1, 16'h0009, 1, 16'h000C, 16'h000B, 1, 16'h0009, 0, 1, 1);
    vecs[32] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000D, 16'h000C, 1, 16'h0000, 1, 1, 1);
    vecs[33] = mk(0, 0, 16'h0000, 1, 16'h0007, 1, 16'h000E, 16'h000D, 1, 16'h0007, 0, 1, 1);
    vecs[34] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000F, 16'h000E, 1, 16'h0000, 1, 1, 1);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset if_valid", 32'(if_valid), 32'd0);
    check("reset if_pc", 32'(if_pc), 32'h0);
    check("reset imem_address", 32'(imem_address), 32'h0);
    check("reset ras_top", 32'(ras_top), 32'h0);
    check("reset ras_empty", 32'(ras_empty), 32'd1);
    check("reset flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      stall         = vecs[i].stall;
      redirect      = vecs[i].redirect;
      redirect_pc   = vecs[i].rpc;
      ras_push      = vecs[i].push;
      ras_push_addr = vecs[i].paddr;
      ras_pop       = vecs[i].pop;
      #1;
      check($sformatf("v%0d imem_stall", i), 32'(imem_stall),
            32'(vecs[i].stall & ~vecs[i].redirect));
      step();
      check($sformatf("v%0d imem_address", i), 32'(imem_address), 32'(vecs[i].e_addr));
      check($sformatf("v%0d if_pc", i), 32'(if_pc), 32'(vecs[i].e_pc));
      check($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid)
        check($sformatf("v%0d if_instruction", i), 32'(if_instruction),
              32'(mem_word(vecs[i].e_pc)));
      check($sformatf("v%0d ras_top", i), 32'(ras_top), 32'(vecs[i].e_top));
      check($sformatf("v%0d ras_empty", i), 32'(ras_empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d ras_overflow", i), 32'(ras_overflow), 32'(vecs[i].e_ovf));
      check($sformatf("v%0d ras_underflow", i), 32'(ras_underflow), 32'(vecs[i].e_unf));
      idle_inputs();
    end

    // Mid-stream reset clears everything immediately, without waiting for an edge.
    rst_n = 1'b0;
    #1;
    check("midrst if_valid", 32'(if_valid), 32'd0);
    check("midrst if_pc", 32'(if_pc), 32'h0);
    check("midrst imem_address", 32'(imem_address), 32'h0);
    check("midrst ras_empty", 32'(ras_empty), 32'd1);
    check("midrst flags", {30'd0, ras_overflow, ras_underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst if_valid", 32'(if_valid), 32'd1);
    check("postrst if_pc", 32'(if_pc), 32'h0);
    check("postrst if_instruction", 32'(if_instruction), 32'(mem_word(16'h0000)));
    check("postrst imem_address", 32'(imem_address), 32'h1);

    // CALL then RET, with the return target taken from ras_top in the pop cycle.
    ras_push = 1; ras_push_addr = 16'h0006;
    step();
    idle_inputs();
    ras_pop = 1; redirect = 1; redirect_pc = 16'h0006;
    #1;
    check("ret ras_top before pop", 32'(ras_top), 32'h6);
    step();
    idle_inputs();
    check("ret ras_empty", 32'(ras_empty), 32'd1);
    check("ret bubble", 32'(if_valid), 32'd0);
    check("ret imem_address", 32'(imem_address), 32'h6);
    step();
    check("ret target valid", 32'(if_valid), 32'd1);
    check("ret target pc", 32'(if_pc), 32'h6);
    check("ret target instr", 32'(if_instruction), 32'(mem_word(16'h0006)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
